// File: rtl/dmem_arb_pkg.sv
// ----------------------------------------------------------------------------
// dmem_arb_pkg
// Shared types for the data-memory arbiter slice.
//   arbState_t : arbiter FSM state (issue slot free / CPU read returning /
//                aux access completing)
//   grant_t    : per-cycle issue decision
//   runCntWidth: width of the CPU run counter for a given run limit
// ----------------------------------------------------------------------------
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CPU_RESP = 2'd1,
        AUX_RESP = 2'd2
    } arbState_t;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_CPU  = 2'd1,
        GNT_AUX  = 2'd2
    } grant_t;

    // Counter must hold the values 0..runMax inclusive.
    function automatic int unsigned runCntWidth(input int unsigned runMax);
        int unsigned w;
        w = $clog2(runMax + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/dmem_arb_grant.sv
// ----------------------------------------------------------------------------
// dmem_arb_grant
// Combinational issue decision for the data-memory arbiter. A new access can
// only be issued while the arbiter is IDLE. The CPU normally wins; the aux
// master wins when the CPU is not requesting or when the CPU has used up its
// run of consecutive grants while aux was waiting.
// Ports:
//   state    in  current arbiter state
//   cpuReq   in  CPU load or store pending
//   auxReq   in  aux request pending
//   runAtMax in  CPU run counter has reached its limit
//   grant    out issue decision for this cycle
// ----------------------------------------------------------------------------
module dmem_arb_grant
    import dmem_arb_pkg::*;
(
    input  arbState_t state,
    input  logic      cpuReq,
    input  logic      auxReq,
    input  logic      runAtMax,
    output grant_t    grant
);

    always_comb begin
        grant = GNT_NONE;
        if (state == IDLE) begin
            if (auxReq && (!cpuReq || runAtMax)) begin
                grant = GNT_AUX;
            end else if (cpuReq) begin
                grant = GNT_CPU;
            end
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// ----------------------------------------------------------------------------
// dmem_arbiter
// Shares the single-port synchronous data memory (dmem4) between the CPU
// load/store path and an auxiliary bus master (debug loader / DMA).
// One access is issued per free cycle; read data returns on mem_rdata the
// cycle after issue. The CPU has priority, but after CPU_RUN_MAX consecutive
// CPU grants with aux waiting, aux is forced a slot.
// Ports:
//   clk, reset         clock, asynchronous active-high reset
//   cpu_rd/cpu_wr      CPU load/store request (level, held while stalled)
//   cpu_addr/cpu_wdata CPU address and store data
//   cpu_rdata          CPU load data (valid when cpu_rd & ~cpu_stall)
//   cpu_stall          CPU must hold its request this cycle
//   aux_req/aux_we     aux request (held until aux_ack), 1 = write
//   aux_addr/aux_wdata aux address and write data
//   aux_rdata/aux_ack  aux read data and one-cycle completion pulse
//   mem_*              connection to dmem4
// ----------------------------------------------------------------------------
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned AW          = 32,
    parameter int unsigned DW          = 32,
    parameter int unsigned CPU_RUN_MAX = 4
) (
    input  logic          clk,
    input  logic          reset,

    input  logic          cpu_rd,
    input  logic          cpu_wr,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_stall,

    input  logic          aux_req,
    input  logic          aux_we,
    input  logic [AW-1:0] aux_addr,
    input  logic [DW-1:0] aux_wdata,
    output logic [DW-1:0] aux_rdata,
    output logic          aux_ack,

    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_we,
    output logic          mem_re,
    input  logic [DW-1:0] mem_rdata
);

    localparam int unsigned RW = runCntWidth(CPU_RUN_MAX);

    arbState_t       state;
    grant_t          grant;
    logic [RW-1:0]   runCnt;
    logic            auxRead;   // in-flight aux access is a read
    logic            cpuReq;
    logic            runAtMax;
    logic            gntCpu;
    logic            gntAux;

    assign cpuReq   = cpu_rd | cpu_wr;
    assign runAtMax = (runCnt == RW'(CPU_RUN_MAX));
    assign gntCpu   = (grant == GNT_CPU);
    assign gntAux   = (grant == GNT_AUX);

    dmem_arb_grant u_grant (
        .state    (state),
        .cpuReq   (cpuReq),
        .auxReq   (aux_req),
        .runAtMax (runAtMax),
        .grant    (grant)
    );

    // Memory port: strobes only on issue cycles. Address/data default to the
    // CPU so the common path has no extra mux select dependence. Strobes are
    // held low while reset is asserted.
    always_comb begin
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        if (!reset) begin
            if (gntAux) begin
                mem_addr  = aux_addr;
                mem_wdata = aux_wdata;
                mem_we    = aux_we;
                mem_re    = ~aux_we;
            end else if (gntCpu) begin
                mem_we = cpu_wr;
                mem_re = cpu_rd;
            end
        end
    end

    // CPU proceeds only on a granted store or on the read-return cycle.
    assign cpu_stall = cpuReq
                     & ~(gntCpu & cpu_wr)
                     & ~((state == CPU_RESP) & cpu_rd);

    // Read data comes straight from dmem4 on the return cycle.
    assign cpu_rdata = (state == CPU_RESP) ? mem_rdata : '0;
    assign aux_rdata = ((state == AUX_RESP) && auxRead) ? mem_rdata : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            runCnt  <= '0;
            aux_ack <= 1'b0;
            auxRead <= 1'b0;
        end else begin
            aux_ack <= gntAux;
            if (gntAux) begin
                auxRead <= ~aux_we;
            end

            case (state)
                IDLE: begin
                    if (gntAux) begin
                        state <= AUX_RESP;
                    end else if (gntCpu && cpu_rd) begin
                        state <= CPU_RESP;
                    end
                end
                CPU_RESP: state <= IDLE;
                AUX_RESP: state <= IDLE;
                default:  state <= IDLE;
            endcase

            // Counts CPU grants taken while aux is waiting; any aux grant or
            // aux withdrawing its request starts the run over.
            if (!aux_req || gntAux) begin
                runCnt <= '0;
            end else if (gntCpu && !runAtMax) begin
                runCnt <= runCnt + 1'b1;
            end
        end
    end

endmodule
